// File: rtl/obstacle_pool_pkg.sv
`default_nettype none
// ============================================================================
// Module      : obstacle_pool_pkg
// Description : Obstacle type codes, widths, draw thresholds and pool FSM
//               state encodings shared by the obstacle pool.
// Revision    : 1.0 - initial release
// ============================================================================
package obstacle_pool_pkg;

    typedef logic [2:0] obst_t;

    localparam obst_t c_LOW_BIRD     = 3'd0;
    localparam obst_t c_HIGH_BIRD    = 3'd1;
    localparam obst_t c_SMALL_CACTUS = 3'd2;
    localparam obst_t c_MANY_CACTUS  = 3'd3;
    localparam obst_t c_BIG_CACTUS   = 3'd4;
    localparam obst_t c_NOTHING      = 3'd5;

    localparam logic [6:0] c_BIG_W   = 7'd27;
    localparam logic [6:0] c_SMALL_W = 7'd19;
    localparam logic [6:0] c_MANY_W  = 7'd77;
    localparam logic [6:0] c_BIRD_W  = 7'd44;

    localparam int c_WINDOW_W = 640;

    localparam logic [6:0] c_RND_NOTHING = 7'd50;
    localparam logic [6:0] c_RND_BIG     = 7'd60;
    localparam logic [6:0] c_RND_SMALL   = 7'd70;
    localparam logic [6:0] c_RND_MANY    = 7'd80;
    localparam logic [6:0] c_RND_LOW     = 7'd90;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_HOLD = 2'd2;

    function automatic logic [6:0] obst_width(input obst_t t);
        case (t)
            c_BIG_CACTUS:           obst_width = c_BIG_W;
            c_SMALL_CACTUS:         obst_width = c_SMALL_W;
            c_MANY_CACTUS:          obst_width = c_MANY_W;
            c_LOW_BIRD, c_HIGH_BIRD: obst_width = c_BIRD_W;
            default:                obst_width = 7'd0;
        endcase
    endfunction

    function automatic obst_t rnd_to_type(input logic [6:0] r);
        if (r <= c_RND_NOTHING)    rnd_to_type = c_NOTHING;
        else if (r <= c_RND_BIG)   rnd_to_type = c_BIG_CACTUS;
        else if (r <= c_RND_SMALL) rnd_to_type = c_SMALL_CACTUS;
        else if (r <= c_RND_MANY)  rnd_to_type = c_MANY_CACTUS;
        else if (r <= c_RND_LOW)   rnd_to_type = c_LOW_BIRD;
        else                       rnd_to_type = c_HIGH_BIRD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/obstacle_slot.sv
`default_nettype none
// ============================================================================
// Module      : obstacle_slot
// Description : One obstacle register (position/type/enable) that scrolls
//               left by i_speed and frees itself when it leaves the screen.
// Revision    : 1.0 - initial release
// ============================================================================
module obstacle_slot
    import obstacle_pool_pkg::*;
#(
    parameter int POS_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_move,
    input  logic             i_load,
    input  logic [POS_W-1:0] i_load_pos,
    input  logic [2:0]       i_load_type,
    input  logic [2:0]       i_speed,
    output logic [POS_W-1:0] o_pos,
    output logic [2:0]       o_type,
    output logic             o_en
);

    logic [POS_W-1:0] r_pos;
    obst_t            r_type;
    logic             r_en;
    logic [POS_W-1:0] w_speed_ext;

    assign w_speed_ext = POS_W'(i_speed);

    // A load takes priority over movement so a fresh obstacle holds still on its spawn tick
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_pos  <= '0;
            r_type <= c_NOTHING;
            r_en   <= 1'b0;
        end else if (i_load) begin
            r_pos  <= i_load_pos;
            r_type <= i_load_type;
            r_en   <= 1'b1;
        end else if (i_move && r_en) begin
            if (r_pos < w_speed_ext) begin
                r_pos  <= '0;
                r_type <= c_NOTHING;
                r_en   <= 1'b0;
            end else begin
                r_pos <= r_pos - w_speed_ext;
            end
        end
    end

    assign o_pos  = r_pos;
    assign o_type = r_type;
    assign o_en   = r_en;

endmodule
`default_nettype wire

// File: rtl/obstacle_pool.sv
`default_nettype none
// ============================================================================
// Module      : obstacle_pool
// Description : Pool of NUM_SLOTS scrolling obstacles with gap-timed random
//               spawning. Optional OBSTACLE_POOL_SPEEDUP_EN raises the scroll
//               speed by one every 8 spawns (saturating at 7).
// Revision    : 1.0 - initial release
// ============================================================================
module obstacle_pool
    import obstacle_pool_pkg::*;
#(
    parameter int NUM_SLOTS = 3,
    parameter int POS_W     = 10,
    parameter int SPAWN_X   = c_WINDOW_W,
    parameter int MIN_GAP   = 400,
    parameter int BACKOFF   = 150
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic                       run,
    input  logic                       clear,
    input  logic [2:0]                 speed,
    input  logic [6:0]                 rnd,
    output logic [NUM_SLOTS*POS_W-1:0] slot_pos,
    output logic [NUM_SLOTS*3-1:0]     slot_type,
    output logic [NUM_SLOTS-1:0]       slot_en,
    output logic                       spawn,
    output logic                       full
);

    localparam int CNT_W = $clog2(MIN_GAP + 1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic                 w_active;
    logic                 w_clr;
    logic [CNT_W-1:0]     r_cnt;
    obst_t                r_next_type;
    logic                 r_spawn;
    logic                 w_draw;
    logic                 w_do_spawn;
    logic                 w_found;
    logic [NUM_SLOTS-1:0] w_load;
    logic [POS_W-1:0]     w_spawn_pos;
    logic [2:0]           w_speed_base;
    logic [2:0]           w_speed_eff;

    assign w_clr = tick && clear;
    assign full  = &slot_en;
    assign spawn = r_spawn;

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (tick) begin
            if (clear)                  w_state_next = c_ST_IDLE;
            else if (run)               w_state_next = c_ST_RUN;
            else if (r_state == c_ST_RUN) w_state_next = c_ST_HOLD;
        end
    end

    // The pool advances on every tick that lands in (or enters) RUN
    always_comb begin
        w_active = tick && !clear && (w_state_next == c_ST_RUN);
    end

    assign w_draw      = w_active && !full && (r_cnt == CNT_W'(MIN_GAP));
    assign w_do_spawn  = w_draw && (r_next_type != c_NOTHING);
    assign w_spawn_pos = POS_W'(SPAWN_X) + POS_W'(obst_width(r_next_type));

    // Free slots are judged on registered enables, so a slot freed this tick waits a tick
    always_comb begin
        w_load  = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!slot_en[i] && !w_found) begin
                w_load[i] = w_do_spawn;
                w_found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            r_cnt       <= '0;
            r_next_type <= c_NOTHING;
            r_spawn     <= 1'b0;
        end else begin
            r_spawn <= w_do_spawn;
            if (w_active) begin
                if (full) begin
                    r_cnt <= '0;
                end else if (r_cnt != CNT_W'(MIN_GAP)) begin
                    r_cnt <= r_cnt + 1'b1;
                end else begin
                    r_next_type <= rnd_to_type(rnd);
                    r_cnt       <= w_do_spawn ? '0 : CNT_W'(MIN_GAP - BACKOFF);
                end
            end
        end
    end

    assign w_speed_base = (speed == 3'd0) ? 3'd1 : speed;

`ifdef OBSTACLE_POOL_SPEEDUP_EN
    logic [2:0] r_spawn_cnt;
    logic [2:0] r_speed_inc;
    logic [3:0] w_speed_sum;

    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            r_spawn_cnt <= '0;
            r_speed_inc <= '0;
        end else if (w_do_spawn) begin
            r_spawn_cnt <= r_spawn_cnt + 3'd1;
            if (r_spawn_cnt == 3'd7 && r_speed_inc != 3'd7)
                r_speed_inc <= r_speed_inc + 3'd1;
        end
    end

    assign w_speed_sum = {1'b0, w_speed_base} + {1'b0, r_speed_inc};
    assign w_speed_eff = (w_speed_sum > 4'd7) ? 3'd7 : w_speed_sum[2:0];
`else
    assign w_speed_eff = w_speed_base;
`endif

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            obstacle_slot #(
                .POS_W (POS_W)
            ) u_slot (
                .clk         (clk),
                .rst         (rst),
                .i_clr       (w_clr),
                .i_move      (w_active),
                .i_load      (w_load[gi]),
                .i_load_pos  (w_spawn_pos),
                .i_load_type (r_next_type),
                .i_speed     (w_speed_eff),
                .o_pos       (slot_pos[gi*POS_W +: POS_W]),
                .o_type      (slot_type[gi*3 +: 3]),
                .o_en        (slot_en[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_obstacle_pool.sv
`default_nettype none
// ============================================================================
// Module      : tb_obstacle_pool
// Description : Scoreboard bench for obstacle_pool: a default instance and a
//               short-gap instance (MIN_GAP 20, BACKOFF 5) used to fill the pool.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obstacle_pool;

    typedef struct {
        int tick_no;
        int slot;
        int pos;
        int typ;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, tick, run_d, run_s, clear;
    logic [2:0] speed;
    logic [6:0] rnd;

    logic [29:0] pos_d, pos_s;
    logic [8:0]  type_d, type_s;
    logic [2:0]  en_d, en_s;
    logic        spawn_d, spawn_s, full_d, full_s;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   tick_cnt = 0;
    int   s_spawns = 0;
    bit   s_count_only = 1'b0;
    exp_t q_d[$];
    exp_t q_s[$];

    always #5 clk = ~clk;

    obstacle_pool dut_d (
        .clk (clk), .rst (rst), .tick (tick), .run (run_d), .clear (clear),
        .speed (speed), .rnd (rnd), .slot_pos (pos_d), .slot_type (type_d),
        .slot_en (en_d), .spawn (spawn_d), .full (full_d)
    );

    obstacle_pool #(.MIN_GAP (20), .BACKOFF (5)) dut_s (
        .clk (clk), .rst (rst), .tick (tick), .run (run_s), .clear (clear),
        .speed (speed), .rnd (rnd), .slot_pos (pos_s), .slot_type (type_s),
        .slot_en (en_s), .spawn (spawn_s), .full (full_s)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int pos_of(input logic [29:0] v, input int i);
        return int'(v[i*10 +: 10]);
    endfunction

    function automatic int typ_of(input logic [8:0] v, input int i);
        return int'(v[i*3 +: 3]);
    endfunction

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick = 1'b1;
            tick_cnt++;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    // Spawn monitors: every spawn pulse is matched against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (spawn_d) begin
            if (q_d.size() == 0) begin
                check("spawn_d unexpected (tick)", tick_cnt, -1);
            end else begin
                e = q_d.pop_front();
                check("spawn_d tick", tick_cnt, e.tick_no);
                check("spawn_d pos", pos_of(pos_d, e.slot), e.pos);
                check("spawn_d type", typ_of(type_d, e.slot), e.typ);
                check("spawn_d en", int'(en_d[e.slot]), 1);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (spawn_s) begin
            s_spawns++;
            if (!s_count_only) begin
                if (q_s.size() == 0) begin
                    check("spawn_s unexpected (tick)", tick_cnt, -1);
                end else begin
                    e = q_s.pop_front();
                    check("spawn_s tick", tick_cnt, e.tick_no);
                    check("spawn_s pos", pos_of(pos_s, e.slot), e.pos);
                    check("spawn_s type", typ_of(type_s, e.slot), e.typ);
                end
            end
        end
    end

    initial begin
`ifdef OBSTACLE_POOL_SPEEDUP_EN
        int guard;
        int p;
        int idx;
`endif
        rst = 1'b1; tick = 1'b0; run_d = 1'b0; run_s = 1'b0; clear = 1'b0;
        speed = 3'd1; rnd = 7'd0;
        repeat (3) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        rst  = 1'b0;
        @(negedge clk);

        check("reset en", int'(en_d), 0);
        check("reset pos", int'(pos_d), 0);
        check("reset type", int'(type_d), 'h16D);
        check("reset spawn", int'(spawn_d), 0);
        check("reset full", int'(full_d), 0);
        check("reset en_s", int'(en_s), 0);

        // Short-gap instance: fill all three slots with LOW_BIRD (684)
        tick_cnt = 0; run_s = 1'b1; rnd = 7'd85; speed = 3'd1;
        q_s.push_back('{27, 0, 684, 0});
        q_s.push_back('{48, 1, 684, 0});
        q_s.push_back('{69, 2, 684, 0});
        q_s.push_back('{733, 0, 684, 0});
        ticks(69);
        check("s full after 3 spawns", int'(full_s), 1);
        check("s en after 3 spawns", int'(en_s), 7);
        check("s slot0 pos @69", pos_of(pos_s, 0), 642);
        ticks(642);
        check("s slot0 pos @711", pos_of(pos_s, 0), 0);
        check("s en @711", int'(en_s), 7);
        ticks(1);
        check("s en after free", int'(en_s), 6);
        check("s full after free", int'(full_s), 0);
        check("s slot0 type after free", typ_of(type_s, 0), 5);
        ticks(21);
        check("s en @733", int'(en_s), 5);
        check("s slot2 pos @733", pos_of(pos_s, 2), 20);
        run_s = 1'b0;

        // Reset with no tick must still clear moving slots
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("rst mid-run en_s", int'(en_s), 0);
        check("rst mid-run pos_s", int'(pos_s), 0);

        // Default instance: first draw sees NOTHING, BIG_CACTUS on the next draw
        tick_cnt = 0; run_d = 1'b1; rnd = 7'd55; speed = 3'd1;
        q_d.push_back('{552, 0, 667, 4});
        ticks(551);
        rnd = 7'd10;
        ticks(1);
        check("d en @552", int'(en_d), 1);
        rnd = 7'd65;
        q_d.push_back('{1104, 1, 659, 2});
        ticks(552);
        check("d en @1104", int'(en_d), 3);
        check("d slot0 pos @1104", pos_of(pos_d, 0), 115);
        ticks(113);
        check("d slot0 pos @1217", pos_of(pos_d, 0), 2);
        speed = 3'd3;
        ticks(1);
        check("d free en", int'(en_d), 2);
        check("d free pos", pos_of(pos_d, 0), 0);
        check("d free type", typ_of(type_d, 0), 5);
        check("d slot1 pos @1218", pos_of(pos_d, 1), 543);

        run_d = 1'b0;
        ticks(100);
        check("hold slot1 pos", pos_of(pos_d, 1), 543);
        check("hold en", int'(en_d), 2);
        run_d = 1'b1;
        ticks(1);
        check("resume slot1 pos", pos_of(pos_d, 1), 540);

        clear = 1'b1;
        ticks(1);
        clear = 1'b0;
        check("clear en", int'(en_d), 0);
        check("clear pos", int'(pos_d), 0);
        check("clear type", int'(type_d), 'h16D);

        // After clear the gap and next type restart; speed 0 moves by 1
        tick_cnt = 0; rnd = 7'd95; speed = 3'd0;
        q_d.push_back('{552, 0, 684, 1});
        ticks(552);
        ticks(10);
        check("speed0 slot0 pos", pos_of(pos_d, 0), 674);
        run_d = 1'b0;

`ifdef OBSTACLE_POOL_SPEEDUP_EN
        s_count_only = 1'b1;
        speed = 3'd1; rnd = 7'd85;
        clear = 1'b1;
        ticks(1);
        clear = 1'b0;
        #1;
        s_spawns = 0;
        run_s = 1'b1;
        guard = 0;
        while (s_spawns < 8 && guard < 3000) begin
            ticks(1);
            #1;
            guard++;
        end
        check("speedup spawns", s_spawns, 8);
        idx = 0;
        for (int i = 2; i >= 0; i--)
            if (en_s[i] && pos_of(pos_s, i) >= 10) idx = i;
        p = pos_of(pos_s, idx);
        ticks(1);
        check("speedup step", p - pos_of(pos_s, idx), 2);
        clear = 1'b1;
        ticks(1);
        clear = 1'b0;
        #1;
        s_spawns = 0;
        guard = 0;
        while (s_spawns < 1 && guard < 200) begin
            ticks(1);
            #1;
            guard++;
        end
        check("post-clear spawns", s_spawns, 1);
        p = pos_of(pos_s, 0);
        ticks(1);
        check("post-clear step", p - pos_of(pos_s, 0), 1);
        run_s = 1'b0;
`endif

        repeat (4) @(negedge clk);
        check("d scoreboard drained", q_d.size(), 0);
        check("s scoreboard drained", q_s.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
